usb_data_buffer: RTL and testbench
==================================

Name: usb_data_buffer

Overview:
64-byte circular FIFO between the AHB-Lite slave and the USB RX/TX engines.
- AHB side: pushes (TX payload) or pops (RX payload) 1, 2 or 4 bytes per access, as set by dataSize.
- USB side: one byte per access.
- Reports byte occupancy back to the slave and the protocol controller. Only one traffic direction is active at a time; the protocol controller issues clear between packets.

Parameters:
DEPTH, 64, buffer capacity in bytes; power of two, 4..128.
OCC_W, $clog2(DEPTH)+1, occupancy width; 7 at default.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clear  in  1  empty buffer, pointers to 0
storeTxData  in  1  AHB push of dataSize bytes from txData
getRxData  in  1  AHB pop of dataSize bytes into rxData
dataSize  in  2  0=1 byte, 1=2 bytes, 2=4 bytes, 3=reserved (treated as 4)
txData  in  32  AHB write data, little-endian, byte0=[7:0]
rxData  out  32  AHB read data, registered
storeRxByte  in  1  USB RX push of rxByte
rxByte  in  8  received byte
getTxByte  in  1  USB TX pop into txByte
txByte  out  8  transmitted byte, registered
bufferOccupancy  out  OCC_W  bytes held, 0..DEPTH
bufferError  out  1  overflow/underflow indication

Behaviour:
- Reset (rst high at clk edge): wrPtr, rdPtr, occupancy, rxData, txByte and bufferError all 0. rst overrides every other input.
- clear (rst low): same effect as reset on pointers and occupancy. rxData and txByte hold their values. Concurrent push/pop in that cycle is ignored and raises no error.
- Push size n: AHB push is 1/2/4 per dataSize; USB push is 1. Byte k of txData goes to address wrPtr+k mod DEPTH (wraps mid-word). wrPtr advances by n.
- Pop size m: same rule. rxData[8k+7:8k] <= mem[rdPtr+k]; unused upper bytes are zero. Data is valid the cycle after getRxData (1-cycle latency). txByte <= mem[rdPtr], also 1-cycle latency.
- Acceptance uses the current-cycle occupancy only:
  - push accepted iff occ + n <= DEPTH;
  - pop accepted iff occ >= m.
  - A push and a pop in the same cycle are both evaluated against the current occ. Same-cycle data is not forwarded; a pop never returns the byte being pushed that cycle.
- Next occupancy = occ + (accepted n) - (accepted m), computed in OCC_W+1 bits. It never exceeds DEPTH and never goes negative.
- Rejected push: no memory write, wrPtr unchanged, error event.
- Rejected pop: rdPtr unchanged, rxData/txByte hold, error event.
- Two push sources active at once (storeTxData and storeRxByte): storeTxData wins; storeRxByte is dropped and raises an error event. Two pop sources active at once: getRxData wins; getTxByte is dropped and raises an error event.
- Full (occ=DEPTH) with simultaneous 1-byte push and 1-byte pop: push rejected, pop accepted, occ becomes DEPTH-1.
- Empty with simultaneous push and pop: pop rejected (error), push accepted.
- Pointers are DEPTH-wrapping modulo counters (low bits of byte address).

Optional Feature:
USB_BUF_STICKY_ERR_EN
- Defined: bufferError is set by any error event and held high until clear or rst.
- Undefined: bufferError is a one-cycle pulse, registered, asserted the cycle after the offending event.

Decomposition:
- Package usb_buf_pkg holds:
  - typedef enum logic[1:0] xferSize_t {SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2};
  - localparam BUF_DEPTH=64;
  - function sizeToBytes(xferSize_t) returning 1/2/4.
- One sub-module, usb_buf_mem: DEPTH x 8 register array with a 4-lane wrapping write port and a 4-lane wrapping read port, indexed by base pointer + lane. Pointer, occupancy and error control stay in usb_data_buffer.

Test Plan:
- Word push 0xDDCCBBAA, then 4 getTxByte -> txByte AA,BB,CC,DD on successive cycles; occupancy 4,3,2,1,0.
- Push 16 words (occ=64), then storeTxData 0x11 -> rejected, occ stays 64, bufferError asserts; payload intact on readback.
- 62 storeRxByte 0x00..0x3D, 62 single-byte pops (rd=wr=62), 4 storeRxByte 0x55,0x66,0x77,0x88, then word getRxData -> rxData 0x88776655 (wraps at 64).
- Empty buffer, getRxData halfword -> rxData holds previous value, occ 0, bufferError pulses (sticky with USB_BUF_STICKY_ERR_EN until clear).
- occ=10, storeTxData word + getTxByte same cycle -> occ 13; storeTxData + storeRxByte same cycle -> only AHB data written, error raised.
- occ=20, assert clear with storeTxData -> occ 0, no error; then rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/usb_buf_pkg.sv
// Shared types and helpers for the USB data buffer.
package usb_buf_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } xferSize_t;

   localparam int BUF_DEPTH = 64;

   // The reserved encoding 3 behaves as a word access.
   function automatic logic [2:0] sizeToBytes(input xferSize_t size);
      logic [2:0] n;
      case (size)
         SIZE_BYTE: n = 3'd1;
         SIZE_HALF: n = 3'd2;
         SIZE_WORD: n = 3'd4;
         default:   n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/usb_buf_mem.sv
// usb_buf_mem: DEPTH x 8 byte array with 4-lane write and read ports that
// wrap around the array end (lane k addresses base + k mod DEPTH).
module usb_buf_mem #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [3:0]    wr_en,
   input  logic [AW-1:0] wr_base,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_base,
   output logic [31:0]   rd_data
);

   logic [7:0] mem_q [DEPTH];

   // Byte-lane writes; AW-bit address arithmetic provides the wrap.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (wr_en[k]) begin
            mem_q[wr_base + AW'(k)] <= wr_data[8*k +: 8];
         end
      end
   end

   // Four consecutive bytes starting at the read pointer.
   always_comb begin
      rd_data = 32'h0000_0000;
      for (int k = 0; k < 4; k++) begin
         rd_data[8*k +: 8] = mem_q[rd_base + AW'(k)];
      end
   end

endmodule

// File: rtl/usb_data_buffer.sv
// usb_data_buffer: circular byte FIFO between the AHB-Lite slave and the USB engines.
// Optional macro USB_BUF_STICKY_ERR_EN: bufferError holds until clear/rst instead of pulsing.
module usb_data_buffer
   import usb_buf_pkg::*;
#(
   parameter int DEPTH = BUF_DEPTH,
   parameter int OCC_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             storeTxData,
   input  logic             getRxData,
   input  logic [1:0]       dataSize,
   input  logic [31:0]      txData,
   output logic [31:0]      rxData,
   input  logic             storeRxByte,
   input  logic [7:0]       rxByte,
   input  logic             getTxByte,
   output logic [7:0]       txByte,
   output logic [OCC_W-1:0] bufferOccupancy,
   output logic             bufferError
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = OCC_W + 1;
   localparam logic [EW-1:0] DEPTH_E = EW'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [31:0]      rx_data_q, rx_data_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic             err_q, err_d;

   logic [2:0]    xfer_bytes, push_n, pop_n;
   logic          push_req, pop_req, push_clash, pop_clash, pop_is_ahb;
   logic          push_ok, pop_ok, err_event;
   logic [31:0]   push_data, mem_rd_data;
   logic [3:0]    wr_lane_en;
   logic [EW-1:0] occ_e;

   // Source arbitration: the AHB side wins on both push and pop.
   always_comb begin
      xfer_bytes = sizeToBytes(xferSize_t'(dataSize));
      if (storeTxData) begin
         push_req   = 1'b1;
         push_n     = xfer_bytes;
         push_data  = txData;
         push_clash = storeRxByte;
      end else if (storeRxByte) begin
         push_req   = 1'b1;
         push_n     = 3'd1;
         push_data  = {24'h00_0000, rxByte};
         push_clash = 1'b0;
      end else begin
         push_req   = 1'b0;
         push_n     = 3'd0;
         push_data  = 32'h0000_0000;
         push_clash = 1'b0;
      end
      if (getRxData) begin
         pop_req    = 1'b1;
         pop_n      = xfer_bytes;
         pop_is_ahb = 1'b1;
         pop_clash  = getTxByte;
      end else if (getTxByte) begin
         pop_req    = 1'b1;
         pop_n      = 3'd1;
         pop_is_ahb = 1'b0;
         pop_clash  = 1'b0;
      end else begin
         pop_req    = 1'b0;
         pop_n      = 3'd0;
         pop_is_ahb = 1'b0;
         pop_clash  = 1'b0;
      end
   end

   // Push and pop are both judged against this cycle's occupancy; clear suppresses both.
   always_comb begin
      occ_e     = {1'b0, occ_q};
      push_ok   = push_req && !clear && ((occ_e + EW'(push_n)) <= DEPTH_E);
      pop_ok    = pop_req && !clear && (occ_e >= EW'(pop_n));
      err_event = !clear && ((push_req && !push_ok) || (pop_req && !pop_ok) ||
                             push_clash || pop_clash);
      for (int k = 0; k < 4; k++) begin
         wr_lane_en[k] = push_ok && (3'(k) < push_n);
      end
   end

   usb_buf_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_lane_en),
      .wr_base (wr_ptr_q),
      .wr_data (push_data),
      .rd_base (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   // Next-state for pointers, occupancy, read data and error flag.
   always_comb begin
      rx_data_d = rx_data_q;
      tx_byte_d = tx_byte_q;
      if (clear) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         occ_d    = {OCC_W{1'b0}};
      end else begin
         wr_ptr_d = push_ok ? (wr_ptr_q + AW'(push_n)) : wr_ptr_q;
         rd_ptr_d = pop_ok ? (rd_ptr_q + AW'(pop_n)) : rd_ptr_q;
         occ_d    = OCC_W'(occ_e + (push_ok ? EW'(push_n) : {EW{1'b0}})
                                 - (pop_ok ? EW'(pop_n) : {EW{1'b0}}));
      end
      if (pop_ok && pop_is_ahb) begin
         for (int k = 0; k < 4; k++) begin
            rx_data_d[8*k +: 8] = (3'(k) < pop_n) ? mem_rd_data[8*k +: 8] : 8'h00;
         end
      end else if (pop_ok) begin
         tx_byte_d = mem_rd_data[7:0];
      end else begin
         tx_byte_d = tx_byte_q;
      end
`ifdef USB_BUF_STICKY_ERR_EN
      err_d = clear ? 1'b0 : (err_q | err_event);
`else
      err_d = err_event;
`endif
   end

   // State registers; rst overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         occ_q     <= {OCC_W{1'b0}};
         rx_data_q <= 32'h0000_0000;
         tx_byte_q <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         rx_data_q <= rx_data_d;
         tx_byte_q <= tx_byte_d;
         err_q     <= err_d;
      end
   end

   assign rxData          = rx_data_q;
   assign txByte          = tx_byte_q;
   assign bufferOccupancy = occ_q;
   assign bufferError     = err_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: directed scenarios plus randomized
// traffic compared against a byte-queue reference model.
module tb_usb_data_buffer;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1, clear = 1'b0;
   logic        storeTxData = 1'b0, getRxData = 1'b0, storeRxByte = 1'b0, getTxByte = 1'b0;
   logic [1:0]  dataSize = 2'd0;
   logic [31:0] txData = 32'h0;
   logic [7:0]  rxByte = 8'h0;
   logic [31:0] rxData;
   logic [7:0]  txByte;
   logic [6:0]  bufferOccupancy;
   logic        bufferError;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mq[$];
   logic [31:0] exp_rx = 32'h0;
   logic [7:0]  exp_tx = 8'h0;
   logic        exp_err = 1'b0;

   usb_data_buffer dut (
      .clk(clk), .rst(rst), .clear(clear),
      .storeTxData(storeTxData), .getRxData(getRxData), .dataSize(dataSize),
      .txData(txData), .rxData(rxData),
      .storeRxByte(storeRxByte), .rxByte(rxByte), .getTxByte(getTxByte),
      .txByte(txByte), .bufferOccupancy(bufferOccupancy), .bufferError(bufferError)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_occ();
      return 7'(mq.size());
   endfunction

   // Reference model: the buffer is a FIFO of bytes; rules applied at the clock edge.
   task automatic model_step();
      int n, pn, pm;
      bit ev, pok, qok;
      logic [31:0] v;
      if (rst) begin
         mq.delete(); exp_rx = 32'h0; exp_tx = 8'h0; exp_err = 1'b0;
         return;
      end
      if (clear) begin
         mq.delete(); exp_err = 1'b0;
         return;
      end
      n  = (dataSize == 2'd0) ? 1 : (dataSize == 2'd1) ? 2 : 4;
      pn = storeTxData ? n : (storeRxByte ? 1 : 0);
      pm = getRxData ? n : (getTxByte ? 1 : 0);
      ev = (storeTxData && storeRxByte) || (getRxData && getTxByte);
      pok = (pn > 0) && (mq.size() + pn <= DEPTH);
      qok = (pm > 0) && (mq.size() >= pm);
      if (pn > 0 && !pok) ev = 1'b1;
      if (pm > 0 && !qok) ev = 1'b1;
      if (qok) begin
         if (getRxData) begin
            v = 32'h0;
            for (int k = 0; k < pm; k++) v[8*k +: 8] = mq.pop_front();
            exp_rx = v;
         end else begin
            exp_tx = mq.pop_front();
         end
      end
      if (pok) begin
         for (int k = 0; k < pn; k++) mq.push_back(storeTxData ? txData[8*k +: 8] : rxByte);
      end
`ifdef USB_BUF_STICKY_ERR_EN
      exp_err = exp_err | ev;
`else
      exp_err = ev;
`endif
   endtask

   task automatic step(input bit r, c, stx, grx, input logic [1:0] ds, input logic [31:0] txd,
                       input bit srx, input logic [7:0] rxb, input bit gtx);
      rst = r; clear = c; storeTxData = stx; getRxData = grx; dataSize = ds;
      txData = txd; storeRxByte = srx; rxByte = rxb; getTxByte = gtx;
      @(posedge clk);
      model_step();
      #1;
      rst = 1'b0; clear = 1'b0; storeTxData = 1'b0; getRxData = 1'b0;
      storeRxByte = 1'b0; getTxByte = 1'b0;
   endtask

   task automatic ahb_push(input logic [1:0] ds, input logic [31:0] d); step(0, 0, 1, 0, ds, d, 0, 8'h0, 0); endtask
   task automatic ahb_pop(input logic [1:0] ds);  step(0, 0, 0, 1, ds, 32'h0, 0, 8'h0, 0); endtask
   task automatic usb_push(input logic [7:0] b);  step(0, 0, 0, 0, 2'd0, 32'h0, 1, b, 0); endtask
   task automatic usb_pop();                      step(0, 0, 0, 0, 2'd0, 32'h0, 0, 8'h0, 1); endtask
   task automatic do_clear();                     step(0, 1, 0, 0, 2'd0, 32'h0, 0, 8'h0, 0); endtask

   task automatic test_reset();
      step(1, 0, 1, 1, 2'd2, $urandom, 1, 8'($urandom), 1);
      checks++;
      if ({rxData, txByte, bufferOccupancy, bufferError} !== 48'h0) begin
         errors++;
         $display("FAIL reset rx=%h tx=%h occ=%0d err=%b required all zero", rxData, txByte, bufferOccupancy, bufferError);
      end
   endtask

   task automatic test_word_to_txbytes();
      logic [7:0] eb [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      ahb_push(2'd2, 32'hDDCC_BBAA);
      checks++;
      if (bufferOccupancy !== 7'd4) begin
         errors++; $display("FAIL word_push_occ got %0d required 4", bufferOccupancy);
      end
      for (int i = 0; i < 4; i++) begin
         usb_pop();
         checks++;
         if (txByte !== eb[i] || bufferOccupancy !== 7'(3 - i)) begin
            errors++;
            $display("FAIL txbyte_seq[%0d] got tx=%h occ=%0d required tx=%h occ=%0d", i, txByte, bufferOccupancy, eb[i], 3 - i);
         end
      end
   endtask

   task automatic test_full();
      logic [31:0] words [16];
      do_clear();
      for (int i = 0; i < 16; i++) begin
         words[i] = $urandom;
         ahb_push(2'd2, words[i]);
      end
      ahb_push(2'd0, 32'h0000_0011);
      checks++;
      if (bufferOccupancy !== 7'd64 || bufferError !== 1'b1) begin
         errors++; $display("FAIL overflow got occ=%0d err=%b required occ=64 err=1", bufferOccupancy, bufferError);
      end
      for (int i = 0; i < 16; i++) begin
         ahb_pop(2'd2);
         checks++;
         if (rxData !== words[i] || bufferOccupancy !== exp_occ() || bufferError !== exp_err) begin
            errors++;
            $display("FAIL full_readback[%0d] got rx=%h occ=%0d err=%b required rx=%h occ=%0d err=%b",
                     i, rxData, bufferOccupancy, bufferError, words[i], exp_occ(), exp_err);
         end
      end
      // Empty: simultaneous push and pop -> pop rejected, push accepted.
      step(0, 0, 1, 0, 2'd0, 32'h0000_0077, 0, 8'h0, 1);
      checks++;
      if (bufferOccupancy !== 7'd1 || bufferError !== 1'b1 || txByte !== exp_tx) begin
         errors++; $display("FAIL empty_push_pop got occ=%0d err=%b tx=%h required occ=1 err=1 tx=%h", bufferOccupancy, bufferError, txByte, exp_tx);
      end
      // Full: simultaneous 1-byte push and pop -> push rejected, pop accepted.
      do_clear();
      for (int i = 0; i < 16; i++) ahb_push(2'd2, $urandom);
      step(0, 0, 1, 0, 2'd0, 32'h0000_0022, 0, 8'h0, 1);
      checks++;
      if (bufferOccupancy !== 7'd63 || bufferError !== 1'b1 || txByte !== exp_tx) begin
         errors++; $display("FAIL full_push_pop got occ=%0d err=%b tx=%h required occ=63 err=1 tx=%h", bufferOccupancy, bufferError, txByte, exp_tx);
      end
   endtask

   task automatic test_wrap();
      do_clear();
      for (int i = 0; i < 62; i++) usb_push(8'(i));
      for (int i = 0; i < 62; i++) begin
         usb_pop();
         checks++;
         if (txByte !== 8'(i)) begin
            errors++; $display("FAIL wrap_fill_pop[%0d] got %h required %h", i, txByte, 8'(i));
         end
      end
      usb_push(8'h55); usb_push(8'h66); usb_push(8'h77); usb_push(8'h88);
      ahb_pop(2'd2);
      checks++;
      if (rxData !== 32'h8877_6655 || bufferOccupancy !== 7'd0) begin
         errors++; $display("FAIL wrap_word got rx=%h occ=%0d required rx=88776655 occ=0", rxData, bufferOccupancy);
      end
   endtask

   task automatic test_underflow();
      ahb_pop(2'd1);
      checks++;
      if (rxData !== 32'h8877_6655 || bufferOccupancy !== 7'd0 || bufferError !== 1'b1) begin
         errors++; $display("FAIL underflow got rx=%h occ=%0d err=%b required rx=88776655 occ=0 err=1", rxData, bufferOccupancy, bufferError);
      end
      step(0, 0, 0, 0, 2'd0, 32'h0, 0, 8'h0, 0);
      checks++;
      if (bufferError !== exp_err) begin
         errors++; $display("FAIL underflow_after got err=%b required %b", bufferError, exp_err);
      end
      do_clear();
      checks++;
      if (bufferError !== 1'b0) begin
         errors++; $display("FAIL underflow_clear got err=%b required 0", bufferError);
      end
   endtask

   task automatic test_concurrent();
      do_clear();
      for (int i = 0; i < 10; i++) usb_push(8'($urandom));
      step(0, 0, 1, 0, 2'd2, $urandom, 0, 8'h0, 1);
      checks++;
      if (bufferOccupancy !== 7'd13 || txByte !== exp_tx || bufferError !== 1'b0) begin
         errors++; $display("FAIL push_pop_same got occ=%0d tx=%h err=%b required occ=13 tx=%h err=0", bufferOccupancy, txByte, bufferError, exp_tx);
      end
      step(0, 0, 1, 0, 2'd0, 32'h0000_00A5, 1, 8'h3C, 0);
      checks++;
      if (bufferOccupancy !== 7'd14 || bufferError !== 1'b1) begin
         errors++; $display("FAIL push_clash got occ=%0d err=%b required occ=14 err=1", bufferOccupancy, bufferError);
      end
      step(0, 0, 0, 1, 2'd0, 32'h0, 0, 8'h0, 1);
      checks++;
      if (bufferOccupancy !== 7'd13 || bufferError !== 1'b1 || rxData !== exp_rx || txByte !== exp_tx) begin
         errors++; $display("FAIL pop_clash got occ=%0d err=%b rx=%h tx=%h required occ=13 err=1 rx=%h tx=%h",
                            bufferOccupancy, bufferError, rxData, txByte, exp_rx, exp_tx);
      end
      for (int i = 0; i < 13; i++) begin
         usb_pop();
         checks++;
         if (txByte !== exp_tx || bufferOccupancy !== exp_occ()) begin
            errors++; $display("FAIL concurrent_drain[%0d] got tx=%h occ=%0d required tx=%h occ=%0d", i, txByte, bufferOccupancy, exp_tx, exp_occ());
         end
      end
   endtask

   task automatic test_clear_reset();
      do_clear();
      for (int i = 0; i < 5; i++) ahb_push(2'd2, $urandom);
      checks++;
      if (bufferOccupancy !== 7'd20) begin
         errors++; $display("FAIL fill20 got occ=%0d required 20", bufferOccupancy);
      end
      step(0, 1, 1, 0, 2'd2, $urandom, 0, 8'h0, 0);
      checks++;
      if (bufferOccupancy !== 7'd0 || bufferError !== 1'b0 || rxData !== exp_rx || txByte !== exp_tx) begin
         errors++; $display("FAIL clear_with_push got occ=%0d err=%b rx=%h tx=%h required occ=0 err=0 rx=%h tx=%h",
                            bufferOccupancy, bufferError, rxData, txByte, exp_rx, exp_tx);
      end
      ahb_push(2'd2, 32'h1234_5678);
      ahb_pop(2'd1);
      usb_pop();
      step(1, 0, 1, 1, 2'd2, $urandom, 1, 8'($urandom), 1);
      checks++;
      if ({rxData, txByte, bufferOccupancy, bufferError} !== 48'h0) begin
         errors++; $display("FAIL reset_midstream rx=%h tx=%h occ=%0d err=%b required all zero", rxData, txByte, bufferOccupancy, bufferError);
      end
   endtask

   task automatic test_random();
      bit push_heavy;
      for (int i = 0; i < 3000; i++) begin
         push_heavy = ((i / 80) % 2) == 0;
         step($urandom_range(0, 499) == 0, $urandom_range(0, 149) == 0,
              $urandom_range(0, 99) < (push_heavy ? 55 : 20), $urandom_range(0, 99) < (push_heavy ? 15 : 45),
              2'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 99) < (push_heavy ? 35 : 10), 8'($urandom),
              $urandom_range(0, 99) < (push_heavy ? 10 : 40));
         checks++;
         if ({rxData, txByte, bufferOccupancy, bufferError} !== {exp_rx, exp_tx, exp_occ(), exp_err}) begin
            errors++;
            $display("FAIL random[%0d] got rx=%h tx=%h occ=%0d err=%b required rx=%h tx=%h occ=%0d err=%b",
                     i, rxData, txByte, bufferOccupancy, bufferError, exp_rx, exp_tx, exp_occ(), exp_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_to_txbytes();
      test_full();
      test_wrap();
      test_underflow();
      test_concurrent();
      test_clear_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
